// File: rtl/otter_mem_pkg.sv
// Shared types and constants for the OTTER data-memory port-2 arbiter.
package otter_mem_pkg;

    typedef enum logic {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_DMA = 1'b1;

    // One requester's view of a memory access.
    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  size;
        logic        sign;
    } mem_req_t;

endpackage

// File: rtl/mem_req_mux.sv
// 2:1 request-field mux in front of memory port 2; drives all zeros when nobody is granted.
module mem_req_mux
    import otter_mem_pkg::*;
(
    input  mem_req_t i_cpu,
    input  mem_req_t i_dma,
    input  logic     i_gnt_cpu,
    input  logic     i_gnt_dma,
    output mem_req_t o_req,
    output logic     o_rden
);

    always_comb begin
        o_req = '0;
        if (i_gnt_cpu) begin
            o_req = i_cpu;
        end else if (i_gnt_dma) begin
            o_req = i_dma;
        end
        o_rden = (i_gnt_cpu || i_gnt_dma) && !o_req.we;
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// CPU/DMA arbiter for shared memory port 2: CPU priority with DMA starvation guard,
// locked DMA bursts capped at BURST_MAX beats, and 1-cycle read response routing.
module mem_port_arbiter
    import otter_mem_pkg::*;
#(
    parameter int MAX_WAIT  = 4,
    parameter int BURST_MAX = 8
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        CPU_REQ,
    input  logic        CPU_WE,
    input  logic [31:0] CPU_ADDR,
    input  logic [31:0] CPU_WDATA,
    input  logic [1:0]  CPU_SIZE,
    input  logic        CPU_SIGN,
    output logic        CPU_GNT,
    output logic        CPU_STALL,
    output logic        CPU_RVALID,
    output logic [31:0] CPU_RDATA,
    input  logic        DMA_REQ,
    input  logic        DMA_WE,
    input  logic        DMA_LOCK,
    input  logic [31:0] DMA_ADDR,
    input  logic [31:0] DMA_WDATA,
    input  logic [1:0]  DMA_SIZE,
    input  logic        DMA_SIGN,
    output logic        DMA_GNT,
    output logic        DMA_RVALID,
    output logic [31:0] DMA_RDATA,
    output logic        MEM_RDEN2,
    output logic        MEM_WE2,
    output logic [31:0] MEM_ADDR2,
    output logic [31:0] MEM_DIN2,
    output logic [1:0]  MEM_SIZE,
    output logic        MEM_SIGN,
    input  logic [31:0] MEM_DOUT2
);

    localparam int WW = $clog2(MAX_WAIT + 1);
    localparam int BW = $clog2(BURST_MAX + 1);
    localparam logic [WW-1:0] WAIT_LIMIT  = WW'(MAX_WAIT);
    localparam logic [BW-1:0] BURST_LIMIT = BW'(BURST_MAX);

    arb_state_t    r_state;
    logic [WW-1:0] r_wait_cnt;
    logic [BW-1:0] r_beat_cnt;
    logic          r_force_cpu;
    logic          r_owner;
    logic          r_rvalid;

    logic          w_cpu_gnt;
    logic          w_dma_gnt;
    logic          w_rden;
    logic          w_rsp;
    logic [BW-1:0] w_beat_next;
    mem_req_t      w_cpu_req;
    mem_req_t      w_dma_req;
    mem_req_t      w_mem_req;

    assign w_cpu_req   = '{we: CPU_WE, addr: CPU_ADDR, wdata: CPU_WDATA, size: CPU_SIZE, sign: CPU_SIGN};
    assign w_dma_req   = '{we: DMA_WE, addr: DMA_ADDR, wdata: DMA_WDATA, size: DMA_SIZE, sign: DMA_SIGN};
    assign w_beat_next = r_beat_cnt + 1'b1;

    // Grants are combinational and suppressed entirely while reset is held.
    always_comb begin
        w_cpu_gnt = 1'b0;
        w_dma_gnt = 1'b0;
        if (!RST) begin
            if (r_state == LOCKED) begin
                w_dma_gnt = DMA_REQ;
            end else if (CPU_REQ && (!DMA_REQ || r_force_cpu || r_wait_cnt != WAIT_LIMIT)) begin
                w_cpu_gnt = 1'b1;
            end else begin
                w_dma_gnt = DMA_REQ;
            end
        end
    end

    mem_req_mux u_mux (
        .i_cpu     (w_cpu_req),
        .i_dma     (w_dma_req),
        .i_gnt_cpu (w_cpu_gnt),
        .i_gnt_dma (w_dma_gnt),
        .o_req     (w_mem_req),
        .o_rden    (w_rden)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= ARB;
            r_wait_cnt  <= '0;
            r_beat_cnt  <= '0;
            r_force_cpu <= 1'b0;
            r_owner     <= REQ_CPU;
            r_rvalid    <= 1'b0;
        end else begin
            r_rvalid    <= w_rden;
            r_owner     <= w_dma_gnt ? REQ_DMA : REQ_CPU;
            r_force_cpu <= 1'b0;

            if (!DMA_REQ || w_dma_gnt) begin
                r_wait_cnt <= '0;
            end else if (r_wait_cnt != WAIT_LIMIT) begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
            end

            case (r_state)
                ARB: begin
                    if (w_dma_gnt && DMA_LOCK) begin
                        // A one-beat burst limit means the opening beat already exhausts it.
                        if (BURST_MAX > 1) begin
                            r_state    <= LOCKED;
                            r_beat_cnt <= BW'(1);
                        end else begin
                            r_force_cpu <= 1'b1;
                        end
                    end
                end
                LOCKED: begin
                    if (!DMA_REQ) begin
                        r_state    <= ARB;
                        r_beat_cnt <= '0;
                    end else if (!DMA_LOCK || w_beat_next == BURST_LIMIT) begin
                        r_state     <= ARB;
                        r_beat_cnt  <= '0;
                        r_wait_cnt  <= '0;
                        r_force_cpu <= (w_beat_next == BURST_LIMIT);
                    end else begin
                        r_beat_cnt <= w_beat_next;
                    end
                end
                default: r_state <= ARB;
            endcase
        end
    end

    // A response still registered from before reset must not leak out during it.
    assign w_rsp = r_rvalid && !RST;

    assign CPU_GNT    = w_cpu_gnt;
    assign DMA_GNT    = w_dma_gnt;
    assign CPU_STALL  = CPU_REQ && !w_cpu_gnt;
    assign CPU_RVALID = w_rsp && (r_owner == REQ_CPU);
    assign DMA_RVALID = w_rsp && (r_owner == REQ_DMA);
    assign CPU_RDATA  = CPU_RVALID ? MEM_DOUT2 : 32'h0;
    assign DMA_RDATA  = DMA_RVALID ? MEM_DOUT2 : 32'h0;

    assign MEM_RDEN2 = w_rden;
    assign MEM_WE2   = w_mem_req.we;
    assign MEM_ADDR2 = w_mem_req.addr;
    assign MEM_DIN2  = w_mem_req.wdata;
    assign MEM_SIZE  = w_mem_req.size;
    assign MEM_SIGN  = w_mem_req.sign;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with default MAX_WAIT=4, BURST_MAX=8.
module tb_mem_port_arbiter;
    import otter_mem_pkg::*;

    logic        CLK = 1'b0;
    logic        RST;
    logic        CPU_REQ, CPU_WE, CPU_SIGN;
    logic [31:0] CPU_ADDR, CPU_WDATA;
    logic [1:0]  CPU_SIZE;
    logic        CPU_GNT, CPU_STALL, CPU_RVALID;
    logic [31:0] CPU_RDATA;
    logic        DMA_REQ, DMA_WE, DMA_LOCK, DMA_SIGN;
    logic [31:0] DMA_ADDR, DMA_WDATA;
    logic [1:0]  DMA_SIZE;
    logic        DMA_GNT, DMA_RVALID;
    logic [31:0] DMA_RDATA;
    logic        MEM_RDEN2, MEM_WE2, MEM_SIGN;
    logic [31:0] MEM_ADDR2, MEM_DIN2, MEM_DOUT2;
    logic [1:0]  MEM_SIZE;

    int n_cmp = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    mem_port_arbiter #(.MAX_WAIT(4), .BURST_MAX(8)) dut (
        .CLK(CLK), .RST(RST),
        .CPU_REQ(CPU_REQ), .CPU_WE(CPU_WE), .CPU_ADDR(CPU_ADDR), .CPU_WDATA(CPU_WDATA),
        .CPU_SIZE(CPU_SIZE), .CPU_SIGN(CPU_SIGN),
        .CPU_GNT(CPU_GNT), .CPU_STALL(CPU_STALL), .CPU_RVALID(CPU_RVALID), .CPU_RDATA(CPU_RDATA),
        .DMA_REQ(DMA_REQ), .DMA_WE(DMA_WE), .DMA_LOCK(DMA_LOCK), .DMA_ADDR(DMA_ADDR),
        .DMA_WDATA(DMA_WDATA), .DMA_SIZE(DMA_SIZE), .DMA_SIGN(DMA_SIGN),
        .DMA_GNT(DMA_GNT), .DMA_RVALID(DMA_RVALID), .DMA_RDATA(DMA_RDATA),
        .MEM_RDEN2(MEM_RDEN2), .MEM_WE2(MEM_WE2), .MEM_ADDR2(MEM_ADDR2), .MEM_DIN2(MEM_DIN2),
        .MEM_SIZE(MEM_SIZE), .MEM_SIGN(MEM_SIGN), .MEM_DOUT2(MEM_DOUT2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Inputs change 2 time units after the rising edge; checks run 1 unit later.
    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    task automatic set_cpu(input logic req, input logic we, input logic [31:0] addr);
        CPU_REQ   = req;
        CPU_WE    = we;
        CPU_ADDR  = addr;
        CPU_WDATA = addr ^ 32'hC0DE_0000;
        CPU_SIZE  = 2'b10;
        CPU_SIGN  = 1'b1;
    endtask

    task automatic set_dma(input logic req, input logic we, input logic lock, input logic [31:0] addr);
        DMA_REQ   = req;
        DMA_WE    = we;
        DMA_LOCK  = lock;
        DMA_ADDR  = addr;
        DMA_WDATA = addr ^ 32'hD0A0_0000;
        DMA_SIZE  = 2'b01;
        DMA_SIGN  = 1'b0;
    endtask

    initial begin
        logic        exp_dma;
        logic [31:0] dma_a;

        RST = 1'b1;
        MEM_DOUT2 = 32'h0;
        set_cpu(1'b1, 1'b0, 32'h100);
        set_dma(1'b1, 1'b0, 1'b0, 32'h200);
        tick(); #1;
        chk("rst_cpu_gnt", 32'(CPU_GNT), 32'd0);
        chk("rst_dma_gnt", 32'(DMA_GNT), 32'd0);
        chk("rst_rden", 32'(MEM_RDEN2), 32'd0);
        chk("rst_we", 32'(MEM_WE2), 32'd0);
        chk("rst_cpu_rvalid", 32'(CPU_RVALID), 32'd0);
        chk("rst_dma_rdata", DMA_RDATA, 32'd0);
        tick();
        RST = 1'b0;
        set_cpu(1'b0, 1'b0, 32'h0);
        set_dma(1'b0, 1'b0, 1'b0, 32'h0);
        #1;
        chk("idle_addr", MEM_ADDR2, 32'h0);
        chk("idle_rden", 32'(MEM_RDEN2), 32'd0);

        // Lone CPU read, then response one cycle later
        tick();
        set_cpu(1'b1, 1'b0, 32'h100);
        #1;
        chk("cpu_rd_gnt", 32'(CPU_GNT), 32'd1);
        chk("cpu_rd_rden", 32'(MEM_RDEN2), 32'd1);
        chk("cpu_rd_addr", MEM_ADDR2, 32'h100);
        chk("cpu_rd_size", 32'(MEM_SIZE), 32'd2);
        chk("cpu_rd_stall", 32'(CPU_STALL), 32'd0);
        tick();
        set_cpu(1'b1, 1'b1, 32'h104);
        MEM_DOUT2 = 32'hDEAD_BEEF;
        #1;
        chk("cpu_rd_rvalid", 32'(CPU_RVALID), 32'd1);
        chk("cpu_rd_rdata", CPU_RDATA, 32'hDEAD_BEEF);
        chk("cpu_rd_dma_rdata", DMA_RDATA, 32'h0);
        chk("cpu_wr_we", 32'(MEM_WE2), 32'd1);
        chk("cpu_wr_din", MEM_DIN2, 32'hC0DE_0104);
        chk("cpu_wr_rden", 32'(MEM_RDEN2), 32'd0);
        tick();
        set_cpu(1'b0, 1'b0, 32'h0);
        #1;
        chk("cpu_wr_no_rvalid", 32'(CPU_RVALID), 32'd0);

        // Both request writes continuously: CPU 4 cycles, DMA on the 5th, CPU again
        for (int i = 1; i <= 6; i++) begin
            tick();
            set_cpu(1'b1, 1'b1, 32'h400);
            set_dma(1'b1, 1'b1, 1'b0, 32'h800);
            #1;
            exp_dma = (i == 5);
            chk($sformatf("starve_cpu_gnt_c%0d", i), 32'(CPU_GNT), 32'(!exp_dma));
            chk($sformatf("starve_dma_gnt_c%0d", i), 32'(DMA_GNT), 32'(exp_dma));
            chk($sformatf("starve_addr_c%0d", i), MEM_ADDR2, exp_dma ? 32'h800 : 32'h400);
        end
        tick();
        set_cpu(1'b0, 1'b0, 32'h0);
        set_dma(1'b0, 1'b0, 1'b0, 32'h0);

        // Locked DMA write burst against a requesting CPU: 8 beats, then a CPU slot
        for (int i = 1; i <= 13; i++) begin
            tick();
            dma_a = 32'h2000 + 32'(i * 4);
            set_cpu(1'b1, 1'b1, 32'h500);
            set_dma(1'b1, 1'b1, 1'b1, dma_a);
            #1;
            exp_dma = (i >= 5 && i <= 12);
            chk($sformatf("burst_dma_gnt_c%0d", i), 32'(DMA_GNT), 32'(exp_dma));
            chk($sformatf("burst_stall_c%0d", i), 32'(CPU_STALL), 32'(exp_dma));
            if (i == 5) chk("burst_beat1_din", MEM_DIN2, 32'hD0A0_2014);
        end
        tick();
        set_cpu(1'b0, 1'b0, 32'h0);
        set_dma(1'b1, 1'b1, 1'b1, 32'h2040);
        #1;
        chk("burst_resume_gnt", 32'(DMA_GNT), 32'd1);
        tick();
        set_cpu(1'b1, 1'b1, 32'h500);
        set_dma(1'b1, 1'b1, 1'b1, 32'h2044);
        #1;
        chk("burst_resume_locked", 32'(CPU_GNT), 32'd0);
        tick();
        set_cpu(1'b0, 1'b0, 32'h0);
        set_dma(1'b0, 1'b0, 1'b0, 32'h0);
        #1;
        chk("burst_drop_no_gnt", 32'(DMA_GNT), 32'd0);
        tick();
        set_cpu(1'b1, 1'b1, 32'h504);
        #1;
        chk("burst_after_arb", 32'(CPU_GNT), 32'd1);

        // Lock dropped on beat 3 releases the port to the waiting CPU
        tick();
        set_cpu(1'b0, 1'b0, 32'h0);
        set_dma(1'b1, 1'b1, 1'b1, 32'h3000);
        #1;
        chk("unlock_b1_gnt", 32'(DMA_GNT), 32'd1);
        tick();
        set_cpu(1'b1, 1'b1, 32'h600);
        set_dma(1'b1, 1'b1, 1'b1, 32'h3004);
        #1;
        chk("unlock_b2_gnt", 32'(DMA_GNT), 32'd1);
        chk("unlock_b2_stall", 32'(CPU_STALL), 32'd1);
        tick();
        set_dma(1'b1, 1'b1, 1'b0, 32'h3008);
        #1;
        chk("unlock_b3_gnt", 32'(DMA_GNT), 32'd1);
        tick();
        #1;
        chk("unlock_cpu_gnt", 32'(CPU_GNT), 32'd1);
        chk("unlock_dma_gnt", 32'(DMA_GNT), 32'd0);

        // DMA read then CPU read: responses routed to their own owners
        tick();
        set_cpu(1'b0, 1'b0, 32'h0);
        set_dma(1'b1, 1'b0, 1'b0, 32'h3100);
        #1;
        chk("xr_dma_rden", 32'(MEM_RDEN2), 32'd1);
        chk("xr_dma_addr", MEM_ADDR2, 32'h3100);
        tick();
        set_cpu(1'b1, 1'b0, 32'h104);
        set_dma(1'b0, 1'b0, 1'b0, 32'h0);
        MEM_DOUT2 = 32'h1111_1111;
        #1;
        chk("xr_cpu_gnt", 32'(CPU_GNT), 32'd1);
        chk("xr_dma_rvalid", 32'(DMA_RVALID), 32'd1);
        chk("xr_dma_rdata", DMA_RDATA, 32'h1111_1111);
        chk("xr_cpu_rvalid0", 32'(CPU_RVALID), 32'd0);
        chk("xr_cpu_rdata0", CPU_RDATA, 32'h0);
        tick();
        set_cpu(1'b0, 1'b0, 32'h0);
        MEM_DOUT2 = 32'h2222_2222;
        #1;
        chk("xr_cpu_rvalid", 32'(CPU_RVALID), 32'd1);
        chk("xr_cpu_rdata", CPU_RDATA, 32'h2222_2222);
        chk("xr_dma_rvalid0", 32'(DMA_RVALID), 32'd0);
        chk("xr_dma_rdata0", DMA_RDATA, 32'h0);

        // Reset right after the beat-2 read of a locked burst
        tick();
        set_dma(1'b1, 1'b0, 1'b1, 32'h4000);
        tick();
        set_dma(1'b1, 1'b0, 1'b1, 32'h4004);
        #1;
        chk("rb_b2_gnt", 32'(DMA_GNT), 32'd1);
        tick();
        RST = 1'b1;
        MEM_DOUT2 = 32'h3333_3333;
        #1;
        chk("rb_rvalid", 32'(DMA_RVALID), 32'd0);
        chk("rb_rdata", DMA_RDATA, 32'h0);
        chk("rb_gnt", 32'(DMA_GNT), 32'd0);
        tick();
        RST = 1'b0;
        set_dma(1'b0, 1'b0, 1'b0, 32'h0);
        #1;
        chk("rb_post_rvalid", 32'(DMA_RVALID), 32'd0);
        chk("rb_post_state", 32'(dut.r_state), 32'(ARB));
        chk("rb_post_wait", 32'(dut.r_wait_cnt), 32'd0);
        chk("rb_post_beat", 32'(dut.r_beat_cnt), 32'd0);
        tick();
        set_cpu(1'b1, 1'b1, 32'h700);
        set_dma(1'b1, 1'b1, 1'b1, 32'h4100);
        #1;
        chk("rb_post_cpu_wins", 32'(CPU_GNT), 32'd1);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
